// File: rtl/frame_gather.sv
// Serial-to-parallel frame assembler: packs encoder symbols into a 384-bit coded frame and
// decoder bits into a 192-bit message frame, each channel with its own FSM and valid/ack handshake.
module frame_gather #(
  parameter int ENC_FRAME_W   = 384,
  parameter int DEC_FRAME_W   = 192,
  parameter int SYM_PER_FRAME = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_g,
  input  logic                   i_code_rate,
  input  logic                   i_enc_valid,
  input  logic [2:0]             i_enc_sym,
  output logic                   o_enc_ready,
  input  logic                   i_enc_ack,
  output logic [ENC_FRAME_W-1:0] o_encoder_out_frame,
  output logic                   o_enc_frame_valid,
  input  logic                   i_dec_valid,
  input  logic                   i_dec_bit,
  output logic                   o_dec_ready,
  input  logic                   i_dec_ack,
  output logic [DEC_FRAME_W-1:0] o_decoder_out_frame,
  output logic                   o_dec_frame_valid
);

  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  localparam int ENC_CNT_W = $clog2(SYM_PER_FRAME);
  localparam int DEC_CNT_W = $clog2(DEC_FRAME_W);
  localparam int ENC_IDX_W = $clog2(ENC_FRAME_W);

  localparam logic [ENC_CNT_W-1:0] ENC_CNT_MAX = ENC_CNT_W'(SYM_PER_FRAME - 1);
  localparam logic [DEC_CNT_W-1:0] DEC_CNT_MAX = DEC_CNT_W'(DEC_FRAME_W - 1);
  localparam logic [ENC_IDX_W-1:0] ENC_TOP3    = ENC_IDX_W'(ENC_FRAME_W - 1);
  localparam logic [ENC_IDX_W-1:0] ENC_TOP2    = ENC_IDX_W'(2 * SYM_PER_FRAME - 1);
  localparam logic [DEC_CNT_W-1:0] DEC_TOP     = DEC_CNT_W'(DEC_FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                 enc_state_reg;
  logic [ENC_CNT_W-1:0]   enc_cnt_reg;
  logic [ENC_FRAME_W-1:0] enc_frame_reg;
  logic                   enc_valid_reg;
  logic                   rate_reg;

  state_t                 dec_state_reg;
  logic [DEC_CNT_W-1:0]   dec_cnt_reg;
  logic [DEC_FRAME_W-1:0] dec_frame_reg;
  logic                   dec_valid_reg;

  logic [ENC_IDX_W-1:0]   enc_k;
  logic [ENC_IDX_W-1:0]   enc_base;
  logic [DEC_CNT_W-1:0]   dec_idx;

  // First symbol lands at the MSB end of the active region; rate 1/2 leaves the top third unused.
  assign enc_k    = ENC_IDX_W'(enc_cnt_reg);
  assign enc_base = (rate_reg == CODE_RATE_3) ? ENC_TOP3 - enc_k * ENC_IDX_W'(3)
                                              : ENC_TOP2 - enc_k * ENC_IDX_W'(2);
  assign dec_idx  = DEC_TOP - dec_cnt_reg;

  assign o_enc_ready         = (enc_state_reg == FILL) & en_g;
  assign o_dec_ready         = (dec_state_reg == FILL) & en_g;
  assign o_encoder_out_frame = enc_frame_reg;
  assign o_enc_frame_valid   = enc_valid_reg;
  assign o_decoder_out_frame = dec_frame_reg;
  assign o_dec_frame_valid   = dec_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_state_reg <= IDLE;
      enc_cnt_reg   <= '0;
      enc_frame_reg <= '0;
      enc_valid_reg <= 1'b0;
      rate_reg      <= CODE_RATE_2;
    end else begin
      case (enc_state_reg)
        IDLE: if (en_g) begin
          enc_state_reg <= FILL;
          rate_reg      <= i_code_rate;
        end
        FILL: if (en_g && i_enc_valid) begin
          enc_frame_reg[enc_base]              <= i_enc_sym[0];
          enc_frame_reg[enc_base - ENC_IDX_W'(1)] <= i_enc_sym[1];
          if (rate_reg == CODE_RATE_3)
            enc_frame_reg[enc_base - ENC_IDX_W'(2)] <= i_enc_sym[2];
          if (enc_cnt_reg == ENC_CNT_MAX) begin
            enc_cnt_reg   <= '0;
            enc_valid_reg <= 1'b1;
            enc_state_reg <= DONE;
          end else begin
            enc_cnt_reg <= enc_cnt_reg + 1'b1;
          end
        end
        DONE: if (i_enc_ack) begin
          enc_valid_reg <= 1'b0;
          enc_frame_reg <= '0;
          enc_cnt_reg   <= '0;
          enc_state_reg <= FILL;
          rate_reg      <= i_code_rate;
        end
        default: enc_state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_state_reg <= IDLE;
      dec_cnt_reg   <= '0;
      dec_frame_reg <= '0;
      dec_valid_reg <= 1'b0;
    end else begin
      case (dec_state_reg)
        IDLE: if (en_g) dec_state_reg <= FILL;
        FILL: if (en_g && i_dec_valid) begin
          dec_frame_reg[dec_idx] <= i_dec_bit;
          if (dec_cnt_reg == DEC_CNT_MAX) begin
            dec_cnt_reg   <= '0;
            dec_valid_reg <= 1'b1;
            dec_state_reg <= DONE;
          end else begin
            dec_cnt_reg <= dec_cnt_reg + 1'b1;
          end
        end
        DONE: if (i_dec_ack) begin
          dec_valid_reg <= 1'b0;
          dec_frame_reg <= '0;
          dec_cnt_reg   <= '0;
          dec_state_reg <= FILL;
        end
        default: dec_state_reg <= IDLE;
      endcase
    end
  end

endmodule
